w_sched_ctrl: RTL
=================

Name: w_sched_ctrl

Overview:
- Sequencer for the SHA-256 message-schedule memory (MOD_W_MEM).
- Accepts one 512-bit block as 16 32-bit words over a valid/ready stream and buffers them.
- Drives the W-memory index I and data input 0..63 in strict ascending order, feeding buffered words for t<16.
- Forwards each W_t, tagged with t, to the compression round over a valid/ready handshake, then pulses BLOCK_DONE.

Parameters:
WORD_W, 32, word width; only 32 supported.
MSG_WORDS, 16, words per message block loaded before the run.
ROUNDS, 64, schedule words emitted per block; index width is 6.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  reset, asynchronous, active-high.
START  in  1  begin a block; sampled only in IDLE.
BUSY  out  1  high in LOAD, RUN and DONE.
MSG_VALID  in  1  MSG_WORD is valid.
MSG_READY  out  1  controller accepts a message word.
MSG_WORD  in  32  message word, big-endian order, word 0 first.
WM_I  out  6  W-memory index I (registered).
WM_DIN  out  32  W-memory D_IN: buf[WM_I] when WM_I<16, else 0.
WM_DOUT  in  32  W-memory D_OUT, valid in the same cycle as WM_I.
W_VALID  out  1  W_DATA/W_T valid toward the round.
W_READY  in  1  round accepts W_DATA.
W_T  out  6  round index of W_DATA (equals WM_I).
W_DATA  out  32  schedule word, combinational pass-through of WM_DOUT.
BLOCK_DONE  out  1  one-cycle pulse after W_63 is accepted.

Behaviour:
- Reset (async, any state): state=IDLE, load count=0, WM_I=0, MSG_READY=0, W_VALID=0, BLOCK_DONE=0, BUSY=0. Buffer contents are don't-care.
- A reset mid-LOAD or mid-RUN discards the block; no BLOCK_DONE pulse is produced.
- IDLE:
  - START=1 -> LOAD on the next edge.
  - MSG_READY=0 and W_VALID=0 in IDLE; MSG_VALID is ignored.
- LOAD:
  - MSG_READY=1.
  - Each cycle with MSG_VALID&MSG_READY writes buf[cnt]=MSG_WORD and increments cnt.
  - On acceptance of word 15: cnt returns to 0, WM_I=0, and the state is RUN on the next edge.
  - Gaps in MSG_VALID are allowed with no timeout.
  - START is ignored in LOAD.
- RUN:
  - W_VALID=1, W_T=WM_I, W_DATA=WM_DOUT, WM_DIN=(WM_I<16)?buf[WM_I]:0. MSG_READY=0.
  - On W_VALID&W_READY with WM_I<63: WM_I increments.
  - On W_VALID&W_READY with WM_I==63: go to DONE. WM_I wraps to 0 and does not advance past 63.
  - While W_READY=0, WM_I and WM_DIN hold stable. W-memory contract: a held index re-presents the same D_OUT and does not advance its history; indices are never skipped or repeated after acceptance.
- DONE: BLOCK_DONE=1 for exactly one cycle, W_VALID=0, then IDLE.
  - START is honoured only once back in IDLE, so the earliest restart is START asserted the cycle after DONE.
- Latency, with MSG_VALID and W_READY held at 1 and START in cycle 0:
  - LOAD in cycles 1-16.
  - RUN in cycles 17-80; W_t is valid in cycle 17+t.
  - BLOCK_DONE in cycle 81.
  - 81 cycles from START to DONE.
- Simultaneous events:
  - MSG_VALID during RUN/DONE/IDLE is not accepted (MSG_READY=0).
  - W_READY outside RUN is ignored.

Test Plan:
- Reset, then idle 5 cycles -> BUSY=0, MSG_READY=0, W_VALID=0, WM_I=0, BLOCK_DONE never pulses.
- START, then "Hello world!" block (0x48656C6C, 0x6F20776F, 0x726C6421, 0x80000000, 0×11, 0x00000060) streamed back-to-back with W_READY=1 -> W_0=0x48656C6C in cycle 17, W_16=0x17470237, W_63=0xB154961C in cycle 80, BLOCK_DONE in cycle 81 only.
- Same block with MSG_VALID toggling every other cycle and W_READY random 50% -> the sequence W_0..W_63 is identical to the previous scenario. Each W_t is accepted exactly once, WM_I is stable during stalls, and W_T is monotonic.
- Assert RST asynchronously mid-RUN at WM_I=37 -> outputs return to reset values immediately with no BLOCK_DONE. A fresh START plus the block then reproduces W_16=0x17470237.
- START held high continuously for two blocks -> the second LOAD begins the cycle after IDLE is re-entered, i.e. 2 cycles after BLOCK_DONE. The second block's W_63 is correct, and MSG words offered during RUN are not consumed (MSG_READY=0).

Source files
------------

// File: rtl/w_sched_ctrl.sv
// SHA-256 message-schedule sequencer: buffers a 16-word block, then walks W-memory index 0..63 toward the round.
// START->BLOCK_DONE is 81 cycles unstalled; MSG_READY is high only in LOAD; the index holds while W_READY=0.
module w_sched_ctrl #(
  parameter int WORD_W    = 32,
  parameter int MSG_WORDS = 16,
  parameter int ROUNDS    = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  output logic                       BUSY,
  input  logic                       MSG_VALID,
  output logic                       MSG_READY,
  input  logic [WORD_W-1:0]          MSG_WORD,
  output logic [$clog2(ROUNDS)-1:0]  WM_I,
  output logic [WORD_W-1:0]          WM_DIN,
  input  logic [WORD_W-1:0]          WM_DOUT,
  output logic                       W_VALID,
  input  logic                       W_READY,
  output logic [$clog2(ROUNDS)-1:0]  W_T,
  output logic [WORD_W-1:0]          W_DATA,
  output logic                       BLOCK_DONE
);

  localparam int IW = $clog2(ROUNDS);
  localparam int CW = $clog2(MSG_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic              msg_ready_q;
  logic              w_valid_q;
  logic              done_q;
  logic              busy_q;
  logic [WORD_W-1:0] msg_buf_q [MSG_WORDS];

  logic msg_fire;
  assign msg_fire = MSG_VALID && msg_ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      msg_ready_q <= 1'b0;
      w_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q     <= S_LOAD;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (msg_fire) begin
            if (cnt_q == CW'(MSG_WORDS - 1)) begin
              cnt_q       <= '0;
              idx_q       <= '0;
              msg_ready_q <= 1'b0;
              w_valid_q   <= 1'b1;
              state_q     <= S_RUN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          // Advance only on an accepted word so the W-memory history steps exactly once per index.
          if (W_READY) begin
            if (idx_q == IW'(ROUNDS - 1)) begin
              idx_q     <= '0;
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          msg_ready_q <= 1'b0;
          w_valid_q   <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Block buffer needs no reset: every entry is rewritten before RUN reads it.
  always_ff @(posedge CLK) begin
    if (state_q == S_LOAD && msg_fire) begin
      msg_buf_q[cnt_q] <= MSG_WORD;
    end
  end

  assign WM_I       = idx_q;
  assign WM_DIN     = (idx_q < IW'(MSG_WORDS)) ? msg_buf_q[idx_q[CW-1:0]] : '0;
  assign W_T        = idx_q;
  assign W_DATA     = WM_DOUT;
  assign W_VALID    = w_valid_q;
  assign MSG_READY  = msg_ready_q;
  assign BLOCK_DONE = done_q;
  assign BUSY       = busy_q;

endmodule
